// File: rtl/instr_prefetch.sv
// Sequential opcode/operand byte prefetcher feeding the control FSM; optional PREFETCH_PERF_EN adds discard_cnt.
// Latency: first byte valid MEM_LAT+1 cycles after ISSUE; steady rate one byte per MEM_LAT+1 cycles.
// Backpressure: byte_ready low holds the head stable; a full FIFO parks the fetcher in HOLD until a pop.

// Small synchronous FIFO with flush; pointers carry an extra wrap bit.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push is dropped only when full with no simultaneous pop.
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] store [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         full;
    logic         empty;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign count   = wr_ptr - rd_ptr;
    // Head reads as zero when empty so the outputs are clean after reset.
    assign rdata   = empty ? '0 : store[rd_ptr[AW-1:0]];

    // Pointer update; flush discards everything, including a same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Data storage needs no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) store[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

module instr_prefetch #(
    parameter int          DEPTH     = 4,
    parameter int          MEM_LAT   = 1,
    parameter logic [15:0] RESET_VEC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] mem_addr,
    output logic        mem_cs,
    output logic        mem_oe,
    input  logic [7:0]  mem_rdata,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic [15:0] byte_pc,
    input  logic        byte_ready,
    input  logic        redirect,
`ifdef PREFETCH_PERF_EN
    output logic [15:0] discard_cnt,
`endif
    input  logic [15:0] redirect_addr
);
    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam logic [2:0]  LAT_INIT = 3'(MEM_LAT);

    typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_HOLD} state_t;

    state_t        state_q;
    state_t        state_d;
    logic [15:0]   fetch_pc_q;
    logic [2:0]    lat_cnt_q;
    logic [CW-1:0] fifo_count;
    logic [23:0]   fifo_rdata;
    logic          fifo_full;
    logic          pop;
    logic          has_slot;
    logic          push;
    logic          lat_load;
    logic          rd_req;

    assign fifo_full  = (fifo_count == CW'(DEPTH));
    assign byte_valid = (fifo_count != '0);
    assign pop        = byte_valid && byte_ready;
    assign has_slot   = !fifo_full || pop;
    assign {byte_data, byte_pc} = fifo_rdata;
    assign mem_cs     = 1'b1;
    assign mem_addr   = fetch_pc_q;
    // Reset holds ISSUE with an empty FIFO; keep the strobe quiet until reset is released.
    assign mem_oe     = rd_req && rst_n;

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .W     (24)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (push),
        .wdata ({mem_rdata, fetch_pc_q}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_ISSUE;
        else        state_q <= state_d;
    end

    // Next state, read strobe and push; redirect overrides everything.
    always_comb begin
        state_d  = state_q;
        rd_req   = 1'b0;
        lat_load = 1'b0;
        push     = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                if (has_slot) begin
                    rd_req   = 1'b1;
                    lat_load = 1'b1;
                    state_d  = ST_WAIT;
                end else begin
                    state_d  = ST_HOLD;
                end
            end
            ST_WAIT: begin
                rd_req = 1'b1;
                if (lat_cnt_q == 3'd1) begin
                    push    = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_HOLD: begin
                if (pop) state_d = ST_ISSUE;
            end
            default: state_d = ST_ISSUE;
        endcase
        if (redirect) begin
            state_d  = ST_ISSUE;
            lat_load = 1'b0;
            push     = 1'b0;
        end
    end

    // Read latency countdown; cleared by redirect so an abandoned read cannot complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     lat_cnt_q <= '0;
        else if (redirect)                              lat_cnt_q <= '0;
        else if (lat_load)                              lat_cnt_q <= LAT_INIT;
        else if (state_q == ST_WAIT && lat_cnt_q != '0) lat_cnt_q <= lat_cnt_q - 3'd1;
    end

    // Fetch address: reload on redirect, advance (with 16-bit wrap) on every push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        fetch_pc_q <= RESET_VEC;
        else if (redirect) fetch_pc_q <= redirect_addr;
        else if (push)     fetch_pc_q <= fetch_pc_q + 16'd1;
    end

`ifdef PREFETCH_PERF_EN
    logic [16:0] disc_sum;
    assign disc_sum = {1'b0, discard_cnt} + 17'(fifo_count);

    // Bytes thrown away by redirects, saturating; the in-flight read is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        discard_cnt <= '0;
        else if (redirect) discard_cnt <= disc_sum[16] ? 16'hFFFF : disc_sum[15:0];
    end
`endif
endmodule
